br_local_port: RTL and testbench
================================

Name: br_local_port

Overview:
- Bridges the DMNI NI's BrLite service interface to the local port of the BrLite broadcast router.
- TX path: accepts one service message from the NI via req/ack, stamps sequence number and source, and injects it into the router with a req/ack handshake.
- RX path: acknowledges router deliveries into a small FIFO and presents the head to the NI as a level "rx available" signal, popped by the NI's one-cycle ack pulse.
- Reports local TX busy status back to the NI.

Parameters:
- ADDRESS, 16'b0: PE address, {x[7:0], y[7:0]}; source field for stamping and loopback filtering.
- RX_DEPTH, 4: RX FIFO entries; power of 2, at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ni_req_i  in  1  NI TX request (level, held until ack seen)
- ni_ack_o  out  1  TX accept pulse to NI
- ni_data_i  in  br_payload_t  NI TX message (ksvc, payload valid; seq_source ignored)
- ni_local_busy_o  out  1  TX path occupied
- ni_rx_o  out  1  RX FIFO non-empty
- ni_ack_i  in  1  NI pop pulse
- ni_data_o  out  br_payload_t  RX FIFO head
- rt_req_o  out  1  injection request to router local input
- rt_ack_i  in  1  router accepted injection
- rt_data_o  out  br_payload_t  injected message
- rt_req_i  in  1  router delivery request
- rt_ack_o  out  1  delivery accepted pulse
- rt_data_i  in  br_payload_t  delivered message

Behaviour:
- Clock and reset: rst_ni asynchronous, active-low; clk_i rising edge. All state is registered.
- Reset values:
  - ni_ack_o, rt_req_o, rt_ack_o = 0.
  - rt_data_o = '0.
  - TX FSM = IDLE; sequence counter = 0; FIFO empty.
  - As a result, ni_rx_o = 0 and ni_local_busy_o = 0.
- Stamping rule: seq_source[15:8] = seq[7:0]; seq_source[7:0] = {ADDRESS[11:8], ADDRESS[3:0]} (4-bit x, 4-bit y).
- TX FSM states: IDLE, SEND.
  - IDLE, ni_req_i=1 and ni_ack_o=0:
    - Latch rt_data_o = {stamped seq_source, ni_data_i.payload, ni_data_i.ksvc}.
    - ni_ack_o <= 1 for exactly one cycle.
    - Go to SEND.
  - SEND:
    - rt_req_o = 1 (registered, asserted from the first SEND cycle); rt_data_o held stable.
    - On rt_ack_i=1: rt_req_o <= 0, seq <= seq + 1 (8-bit wrap, 0xFF -> 0x00), return to IDLE.
    - rt_ack_i may arrive on the first SEND cycle.
  - ni_req_i is ignored while in SEND or while ni_ack_o=1. This covers the NI's one-cycle drop latency, so no double acceptance occurs.
  - ni_local_busy_o = (state == SEND) | ni_ack_o, combinational from registers.
  - rt_ack_i in IDLE is ignored.
- RX path:
  - Accept when rt_req_i=1, rt_ack_o=0, and the FIFO is not full, evaluating full including a same-cycle pop.
  - On accept: rt_ack_o <= 1 for one cycle; the message is pushed unless it is loopback.
  - Loopback: rt_data_i.seq_source[7:0] equals own stamp source. The message is acknowledged but not pushed.
  - FIFO full with no pop: rt_ack_o stays 0 (backpressure); the router holds req.
  - ni_rx_o = !empty; ni_data_o = head entry, combinational from FIFO storage.
  - ni_ack_i=1 with the FIFO non-empty: pop; head advances next cycle.
  - ni_ack_i with the FIFO empty is ignored.
  - Push and pop in the same cycle: both occur; count unchanged. When full, a same-cycle pop permits the push.
  - Read/write pointers are log2(RX_DEPTH)+1 bits: wrap on the index bits, full/empty from the MSB comparison.
- TX and RX are fully independent; simultaneous activity is allowed.
- Reset asserted mid-transfer: all state clears immediately. An in-flight TX message is lost (no retry), the sequence counter restarts at 0, and FIFO contents are discarded.

Test Plan:
- Single TX (ADDRESS=16'h0201):
  - Stimulus: ni_req_i with ksvc=4'h5, payload=16'hBEEF; rt_ack_i returned 3 cycles after rt_req_o rises.
  - Required: ni_ack_o is a single pulse; rt_data_o.seq_source = 16'h0021; rt_req_o drops the cycle after rt_ack_i; busy is high throughout.
- Back-to-back TX:
  - Stimulus: 257 messages.
  - Required: seq fields 0x00..0xFF then 0x00; no message accepted twice; ni_req_i held one extra cycle after ack is not re-accepted.
- RX fill to full (RX_DEPTH=4):
  - Stimulus: 5 router deliveries (payloads 1..5), no NI ack.
  - Required: first 4 acked; 5th gets rt_ack_o=0 until one ni_ack_i pop, then acked. NI pops in order: 1, 2, 3, 4, 5.
- Simultaneous push/pop:
  - Stimulus: a pop and a delivery in the same cycle, with the FIFO at 1 entry and at full.
  - Required: count unchanged; data order preserved.
- Loopback:
  - Stimulus: delivery with seq_source[7:0]=8'h21 at ADDRESS=16'h0201.
  - Required: rt_ack_o pulses; ni_rx_o stays 0.
- Reset:
  - Stimulus: rst_ni low during SEND and with 2 RX entries.
  - Required: rt_req_o=0, ni_rx_o=0, busy=0 immediately; next TX is stamped seq=0.

Source files
------------

// File: rtl/br_local_port.sv
// BrLite local-port bridge: NI service-message TX/RX to the broadcast router's local port.
// TX stamps sequence/source and injects; RX buffers router deliveries in a small FIFO.
package br_local_port_pkg;
    localparam int unsigned SEQ_SRC_W = 16;
    localparam int unsigned PAYLOAD_W = 16;
    localparam int unsigned KSVC_W    = 4;

    typedef struct packed {
        logic [SEQ_SRC_W-1:0] seq_source;
        logic [PAYLOAD_W-1:0] payload;
        logic [KSVC_W-1:0]    ksvc;
    } br_payload_t;
endpackage

module br_local_port
    import br_local_port_pkg::*;
#(
    parameter logic [15:0] ADDRESS  = 16'b0,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ni_req_i,
    output logic        ni_ack_o,
    input  br_payload_t ni_data_i,
    output logic        ni_local_busy_o,
    output logic        ni_rx_o,
    input  logic        ni_ack_i,
    output br_payload_t ni_data_o,
    output logic        rt_req_o,
    input  logic        rt_ack_i,
    output br_payload_t rt_data_o,
    input  logic        rt_req_i,
    output logic        rt_ack_o,
    input  br_payload_t rt_data_i
);
    localparam int unsigned IDX_W   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int unsigned PTR_W   = IDX_W + 1;
    localparam logic [7:0]  OWN_SRC = {ADDRESS[11:8], ADDRESS[3:0]};

    typedef enum logic {IDLE, SEND} tx_state_t;

    tx_state_t  tx_state;
    logic [7:0] seq;

    // The NI supplies its own seq_source field; the bridge always overwrites it.
    logic unused_ni_seq_source;
    assign unused_ni_seq_source = ^ni_data_i.seq_source;

    // TX: accept one message, stamp it, hold it on the router port until acked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state  <= IDLE;
            seq       <= '0;
            ni_ack_o  <= 1'b0;
            rt_req_o  <= 1'b0;
            rt_data_o <= '0;
        end else begin
            ni_ack_o <= 1'b0;
            case (tx_state)
                IDLE: begin
                    if (ni_req_i && !ni_ack_o) begin
                        rt_data_o.seq_source <= {seq, OWN_SRC};
                        rt_data_o.payload    <= ni_data_i.payload;
                        rt_data_o.ksvc       <= ni_data_i.ksvc;
                        ni_ack_o             <= 1'b1;
                        rt_req_o             <= 1'b1;
                        tx_state             <= SEND;
                    end
                end
                SEND: begin
                    if (rt_ack_i) begin
                        rt_req_o <= 1'b0;
                        seq      <= seq + 8'(1);
                        tx_state <= IDLE;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    assign ni_local_busy_o = (tx_state == SEND) | ni_ack_o;

    // RX FIFO with one extra pointer bit to tell full from empty.
    br_payload_t      mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;
    logic             push;
    logic             loopback;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W])
                   && (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign pop      = ni_ack_i && !empty;
    assign loopback = (rt_data_i.seq_source[7:0] == OWN_SRC);
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign accept   = rt_req_i && !rt_ack_o && (!full || pop);
    assign push     = accept && !loopback;

    assign ni_rx_o   = !empty;
    assign ni_data_o = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rt_ack_o <= 1'b0;
            for (int i = 0; i < int'(RX_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            rt_ack_o <= accept;
            if (push) begin
                mem[wr_ptr[IDX_W-1:0]] <= rt_data_i;
                wr_ptr                 <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_br_local_port.sv
// Bench for br_local_port: queue-based reference model, separate monitor, random and directed traffic.
module tb_br_local_port;
    import br_local_port_pkg::*;

    localparam logic [15:0] ADDR  = 16'h0201;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  SRC   = 8'h21;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ni_req_i = 1'b0;
    logic        ni_ack_o;
    br_payload_t ni_data_i = '0;
    logic        ni_local_busy_o;
    logic        ni_rx_o;
    logic        ni_ack_i = 1'b0;
    br_payload_t ni_data_o;
    logic        rt_req_o;
    logic        rt_ack_i = 1'b0;
    br_payload_t rt_data_o;
    logic        rt_req_i = 1'b0;
    logic        rt_ack_o;
    br_payload_t rt_data_i = '0;

    br_local_port #(.ADDRESS(ADDR), .RX_DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .ni_req_i        (ni_req_i),
        .ni_ack_o        (ni_ack_o),
        .ni_data_i       (ni_data_i),
        .ni_local_busy_o (ni_local_busy_o),
        .ni_rx_o         (ni_rx_o),
        .ni_ack_i        (ni_ack_i),
        .ni_data_o       (ni_data_o),
        .rt_req_o        (rt_req_o),
        .rt_ack_i        (rt_ack_i),
        .rt_data_o       (rt_data_o),
        .rt_req_i        (rt_req_i),
        .rt_ack_o        (rt_ack_o),
        .rt_data_i       (rt_data_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail = 0;
    br_payload_t tx_q[$];
    br_payload_t rx_q[$];
    logic [7:0]  seq_m = 8'h00;
    bit          resp_en = 1'b1;
    bit          spurious_en = 1'b0;
    int          wait_cnt = 0;
    bit          prev_ni_ack = 1'b0;
    bit          prev_hs = 1'b0;
    int          n_tx_issued = 0;
    int          n_tx_accepted = 0;
    bit          rx_done = 1'b0;
    br_payload_t mon_exp;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void note_fail(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected at %0t", name, $time);
    endfunction

    // Monitor: pops the model queues whenever the DUT completes a handshake.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_ni_ack = 1'b0;
            prev_hs     = 1'b0;
        end else begin
            if (ni_ack_o) begin
                n_tx_accepted++;
                chk("ni_ack_single_pulse", 64'(prev_ni_ack), 64'(0));
            end
            if (prev_hs) chk("rt_req_drop_after_ack", 64'(rt_req_o), 64'(0));
            if (rt_req_o || ni_ack_o) chk("busy_while_tx", 64'(ni_local_busy_o), 64'(1));
            else chk("busy_idle", 64'(ni_local_busy_o), 64'(0));
            if (rt_req_o && rt_ack_i) begin
                if (tx_q.size() == 0) note_fail("tx_unexpected_inject");
                else begin
                    mon_exp = tx_q.pop_front();
                    chk("tx_data", 64'(rt_data_o), 64'(mon_exp));
                end
            end
            if (ni_rx_o && ni_ack_i) begin
                if (rx_q.size() == 0) note_fail("rx_unexpected_pop");
                else begin
                    mon_exp = rx_q.pop_front();
                    chk("rx_data", 64'(ni_data_o), 64'(mon_exp));
                end
            end
            prev_ni_ack = ni_ack_o;
            prev_hs     = rt_req_o && rt_ack_i;
        end
    end

    // Router responder: acks injections after wait_cnt cycles, optionally spurious acks in idle.
    initial forever begin
        @(posedge clk_i); #1;
        if (!rst_ni || rt_ack_i) rt_ack_i = 1'b0;
        else if (rt_req_o && resp_en) begin
            if (wait_cnt == 0) begin
                rt_ack_i = 1'b1;
                wait_cnt = $urandom_range(0, 3);
            end else wait_cnt--;
        end else if (!rt_req_o && spurious_en && $urandom_range(0, 7) == 0) rt_ack_i = 1'b1;
    end

    task automatic send_msg(input logic [3:0] k, input logic [15:0] p);
        br_payload_t e;
        bit got;
        e.seq_source = {seq_m, SRC};
        e.payload    = p;
        e.ksvc       = k;
        tx_q.push_back(e);
        seq_m = seq_m + 8'h01;
        n_tx_issued++;
        @(posedge clk_i); #1;
        ni_req_i             = 1'b1;
        ni_data_i.ksvc       = k;
        ni_data_i.payload    = p;
        ni_data_i.seq_source = 16'($urandom);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (ni_ack_o) begin got = 1'b1; break; end
        end
        if (!got) note_fail("ni_ack_timeout");
        // Request is still high in the ack cycle, as a registered NI would leave it.
        @(posedge clk_i); #1;
        ni_req_i = 1'b0;
    endtask

    task automatic wait_tx_done();
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (tx_q.size() == 0 && !rt_req_o) begin done = 1'b1; break; end
        end
        if (!done) note_fail("tx_drain_timeout");
    endtask

    task automatic rx_start(input br_payload_t d);
        if (d.seq_source[7:0] != SRC) rx_q.push_back(d);
        @(posedge clk_i); #1;
        rt_req_i  = 1'b1;
        rt_data_i = d;
    endtask

    task automatic rx_wait_ack(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (rt_ack_o) begin got = 1'b1; break; end
        end
        @(posedge clk_i); #1;
        rt_req_i = 1'b0;
    endtask

    task automatic deliver(input br_payload_t d, input string name);
        bit got;
        rx_start(d);
        rx_wait_ack(20, got);
        chk(name, 64'(got), 64'(1));
    endtask

    task automatic pop_pulse();
        @(posedge clk_i); #1;
        ni_ack_i = 1'b1;
        @(posedge clk_i); #1;
        ni_ack_i = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_i);
            if (!ni_rx_o) break;
            pop_pulse();
            n++;
        end
    endtask

    function automatic br_payload_t mk(input logic [7:0] src, input logic [15:0] p);
        br_payload_t d;
        d.seq_source = {8'($urandom), src};
        d.payload    = p;
        d.ksvc       = 4'($urandom);
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;
        bit blocked;
        br_payload_t d;

        // Reset values
        #12;
        chk("rst_ni_ack", 64'(ni_ack_o), 64'(0));
        chk("rst_rt_req", 64'(rt_req_o), 64'(0));
        chk("rst_rt_ack", 64'(rt_ack_o), 64'(0));
        chk("rst_rt_data", 64'(rt_data_o), 64'(0));
        chk("rst_ni_rx", 64'(ni_rx_o), 64'(0));
        chk("rst_busy", 64'(ni_local_busy_o), 64'(0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Single TX with a 3-cycle router ack delay
        wait_cnt = 3;
        send_msg(4'h5, 16'hBEEF);
        chk("single_tx_stamp", 64'(rt_data_o.seq_source), 64'(16'h0021));
        wait_tx_done();

        // Back-to-back TX (seq wraps) concurrent with random RX traffic and pops
        spurious_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 256; i++) send_msg(4'($urandom), 16'($urandom));
                wait_tx_done();
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    d = mk(($urandom_range(0, 5) == 0) ? SRC : 8'($urandom), 16'($urandom));
                    rx_start(d);
                    rx_wait_ack(500, got);
                    chk("rand_rx_ack", 64'(got), 64'(1));
                    repeat ($urandom_range(0, 3)) @(posedge clk_i);
                end
                rx_done = 1'b1;
            end
            begin
                for (int i = 0; i < 20000; i++) begin
                    @(posedge clk_i); #1;
                    ni_ack_i = ($urandom_range(0, 1) == 1);
                    if (rx_done && !ni_rx_o) break;
                end
                ni_ack_i = 1'b0;
            end
        join
        spurious_en = 1'b0;
        chk("seq_model_wrapped", 64'(seq_m), 64'(8'h01));
        @(negedge clk_i);
        chk("rand_rx_empty", 64'(ni_rx_o), 64'(0));

        // RX fill to full, fifth delivery back-pressured until one pop
        for (int i = 1; i <= 4; i++) deliver(mk(8'h35, 16'(i)), "fill_ack");
        rx_start(mk(8'h35, 16'd5));
        blocked = 1'b1;
        repeat (6) begin
            @(negedge clk_i);
            if (rt_ack_o) blocked = 1'b0;
        end
        chk("full_backpressure", 64'(blocked), 64'(1));
        pop_pulse();
        rx_wait_ack(5, got);
        chk("ack_after_pop", 64'(got), 64'(1));
        drain(n);
        chk("fill_drain_count", 64'(n), 64'(4));

        // Same-cycle push and pop with one entry stored
        deliver(mk(8'h44, 16'hA001), "simul1_pre_ack");
        d = mk(8'h44, 16'hA002);
        rx_q.push_back(d);
        @(posedge clk_i); #1;
        rt_req_i  = 1'b1;
        rt_data_i = d;
        ni_ack_i  = 1'b1;
        @(posedge clk_i); #1;
        ni_ack_i = 1'b0;
        @(negedge clk_i);
        chk("simul1_ack", 64'(rt_ack_o), 64'(1));
        chk("simul1_head", 64'(ni_data_o), 64'(d));
        @(posedge clk_i); #1;
        rt_req_i = 1'b0;
        drain(n);
        chk("simul1_count", 64'(n), 64'(1));

        // Same-cycle push and pop with the FIFO full
        for (int i = 0; i < 4; i++) deliver(mk(8'h52, 16'hC000 + 16'(i)), "simul_full_pre_ack");
        d = mk(8'h52, 16'hC004);
        rx_q.push_back(d);
        @(posedge clk_i); #1;
        rt_req_i  = 1'b1;
        rt_data_i = d;
        ni_ack_i  = 1'b1;
        @(posedge clk_i); #1;
        ni_ack_i = 1'b0;
        @(negedge clk_i);
        chk("simul_full_ack", 64'(rt_ack_o), 64'(1));
        @(posedge clk_i); #1;
        rt_req_i = 1'b0;
        drain(n);
        chk("simul_full_count", 64'(n), 64'(4));

        // Loopback: acknowledged but never presented to the NI
        deliver(mk(SRC, 16'h1234), "loopback_ack");
        repeat (2) @(negedge clk_i);
        chk("loopback_no_rx", 64'(ni_rx_o), 64'(0));

        // Reset mid-transfer: TX stuck in SEND, two RX entries stored
        resp_en = 1'b0;
        send_msg(4'h3, 16'h5555);
        deliver(mk(8'h66, 16'h0101), "pre_rst_ack");
        deliver(mk(8'h66, 16'h0202), "pre_rst_ack");
        @(negedge clk_i);
        chk("pre_rst_rt_req", 64'(rt_req_o), 64'(1));
        chk("pre_rst_rx", 64'(ni_rx_o), 64'(1));
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        chk("midrst_rt_req", 64'(rt_req_o), 64'(0));
        chk("midrst_ni_rx", 64'(ni_rx_o), 64'(0));
        chk("midrst_busy", 64'(ni_local_busy_o), 64'(0));
        tx_q.delete();
        rx_q.delete();
        seq_m = 8'h00;
        resp_en = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        send_msg(4'h9, 16'h0F0F);
        chk("post_rst_seq0", 64'(rt_data_o.seq_source), 64'(16'h0021));
        wait_tx_done();
        @(negedge clk_i);
        chk("post_rst_rx_empty", 64'(ni_rx_o), 64'(0));

        chk("tx_accept_count", 64'(n_tx_accepted), 64'(n_tx_issued));
        chk("tx_queue_empty", 64'(tx_q.size()), 64'(0));
        chk("rx_queue_empty", 64'(rx_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
